// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg: shared types and defaults for the RAM port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t GNT_I = 2'd1;
  localparam arb_state_t GNT_D = 2'd2;
  localparam arb_state_t ERR   = 2'd3;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 64;

  // Bits needed to hold values 0..maxval.
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if: requester-side and RAM-side signals of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        err;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  // Requesters plus RAM model side.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_priority.sv
// ---------------------------------------------------------------------------
// mem_arbiter_priority: data-first grant select with starvation override
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter_priority
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = 3
) (
  input  logic          iren,
  input  logic          dreq,
  input  logic [CW-1:0] starve_cnt,
  output logic          gnt_d,
  output logic          gnt_i
);

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  always_comb begin
    gnt_d = dreq & ((starve_cnt < STARVE_LIM) | ~iren);
    gnt_i = iren & ~gnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: shares one RAM port between instruction fetch and data access
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int SW = cnt_w(STARVE_MAX);
  localparam int TW = cnt_w(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          dreq;
  logic          access;
  logic          idone;
  logic          ddone;
  logic          owner_en;
  logic          gnt_d;
  logic          gnt_i;

  assign dreq     = bus.dREN | bus.dWEN;
  assign access   = (bus.ramstate == ACCESS);
  assign idone    = (state == GNT_I) & access;
  assign ddone    = (state == GNT_D) & access;
  assign owner_en = (state == GNT_I) ? bus.iREN : dreq;

  assign bus.iwait = bus.iREN & ~idone;
  assign bus.dwait = dreq & ~ddone;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  mem_arbiter_priority #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (SW)
  ) u_priority (
    .iren       (bus.iREN),
    .dreq       (dreq),
    .starve_cnt (starve_cnt),
    .gnt_d      (gnt_d),
    .gnt_i      (gnt_i)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      tmo_cnt      <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      bus.err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (gnt_d) begin
            // A simultaneous read and write request is served as a write.
            state        <= GNT_D;
            bus.ramWEN   <= bus.dWEN;
            bus.ramREN   <= ~bus.dWEN;
            bus.ramaddr  <= bus.daddr;
            bus.ramstore <= bus.dstore;
            if (!bus.iREN)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (gnt_i) begin
            state       <= GNT_I;
            bus.ramREN  <= 1'b1;
            bus.ramaddr <= bus.iaddr;
            starve_cnt  <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (access || !owner_en) begin
            state      <= IDLE;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            tmo_cnt    <= '0;
          end else if (bus.ramstate == ERROR || tmo_cnt == TMO_LAST) begin
            state      <= ERR;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            bus.err    <= 1'b1;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          bus.ramREN <= 1'b0;
          bus.ramWEN <= 1'b0;
          bus.err    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: directed table, corner sequences and randomized model check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int SM  = 4;
  localparam int TMO = 64;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds;
    ramstate_t   rs;
    logic [31:0] rl;
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    bit active;
    bit is_d;
    bit wr;
    int age;
  } txn_t;

  vec_t        tbl[11];
  txn_t        cur;
  int          m_starve, m_errcyc;
  bit          m_err;
  logic [31:0] m_addr, m_store;
  logic [31:0] grants[$];

  function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                              input ramstate_t rs, input logic [31:0] rl,
                              input logic eiw, edw, eren, ewen, input logic [31:0] eaddr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.e_iw = eiw; v.e_dw = edw; v.e_ren = eren;
    v.e_wen = ewen; v.e_addr = eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                        input ramstate_t rs, input logic [31:0] rl);
    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramstate = rs; bus.ramload = rl;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset;
    cur = '{0, 0, 0, 0};
    m_starve = 0; m_err = 0; m_errcyc = 0;
    m_addr = '0; m_store = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1,0,0,32'h40,32'h0,  32'h0,FREE,  32'h0,        1,0,0,0,32'h0);
    tbl[1]  = mk(1,0,0,32'h40,32'h0,  32'h0,BUSY,  32'h0,        1,0,1,0,32'h40);
    tbl[2]  = mk(1,0,0,32'h40,32'h0,  32'h0,ACCESS,32'h8C010004, 0,0,1,0,32'h40);
    tbl[3]  = mk(0,0,0,32'h40,32'h0,  32'h0,FREE,  32'h0,        0,0,0,0,32'h40);
    tbl[4]  = mk(1,1,0,32'h44,32'h100,32'h0,FREE,  32'h0,        1,1,0,0,32'h40);
    tbl[5]  = mk(1,1,0,32'h44,32'h100,32'h0,BUSY,  32'h0,        1,1,1,0,32'h100);
    tbl[6]  = mk(1,1,0,32'h44,32'h100,32'h0,ACCESS,32'h11112222, 1,0,1,0,32'h100);
    tbl[7]  = mk(1,0,0,32'h44,32'h100,32'h0,FREE,  32'h0,        1,0,0,0,32'h100);
    tbl[8]  = mk(1,0,0,32'h44,32'h0,  32'h0,BUSY,  32'h0,        1,0,1,0,32'h44);
    tbl[9]  = mk(1,0,0,32'h44,32'h0,  32'h0,ACCESS,32'h22223333, 0,0,1,0,32'h44);
    tbl[10] = mk(0,0,0,32'h0, 32'h0,  32'h0,FREE,  32'h0,        0,0,0,0,32'h44);

    // Reset state
    set_in(0,0,0,0,0,0,FREE,0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_ramWEN", bus.ramWEN, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_iwait", bus.iwait, 0);
    nRST = 1'b1;

    // Instruction-only and contention vectors
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rs, tbl[i].rl);
      @(negedge CLK);
      chk($sformatf("tbl%0d_iwait", i), bus.iwait, tbl[i].e_iw);
      chk($sformatf("tbl%0d_dwait", i), bus.dwait, tbl[i].e_dw);
      chk($sformatf("tbl%0d_ramREN", i), bus.ramREN, tbl[i].e_ren);
      chk($sformatf("tbl%0d_ramWEN", i), bus.ramWEN, tbl[i].e_wen);
      chk($sformatf("tbl%0d_ramaddr", i), bus.ramaddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_err", i), bus.err, 0);
      if (tbl[i].ir && !tbl[i].e_iw) chk($sformatf("tbl%0d_iload", i), bus.iload, tbl[i].rl);
      if (tbl[i].dr && !tbl[i].e_dw) chk($sformatf("tbl%0d_dload", i), bus.dload, tbl[i].rl);
      tick();
    end

    // Starvation: data held continuously alongside instruction
    set_in(1,1,0,32'h40,32'h100,0,ACCESS,32'h5A5A5A5A);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.ramREN) begin
        grants.push_back(bus.ramaddr);
        if (bus.ramaddr == 32'h100) chk("starve_iwait_during_d", bus.iwait, 1);
      end
      tick();
    end
    chk("starve_grant_count", grants.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < grants.size())
        chk($sformatf("starve_grant%0d", k), grants[k], (k % 5 == 4) ? 32'h40 : 32'h100);
    set_in(0,0,0,0,0,0,FREE,0);
    tick(); tick();

    // Write with address/data change mid-grant
    set_in(0,0,1,0,32'h200,32'hDEADBEEF,FREE,0);
    @(negedge CLK);
    chk("wr_idle_ramWEN", bus.ramWEN, 0);
    chk("wr_idle_dwait", bus.dwait, 1);
    tick();
    set_in(0,0,1,0,32'h300,32'h0,BUSY,0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("wr_ramWEN", bus.ramWEN, 1);
      chk("wr_ramREN", bus.ramREN, 0);
      chk("wr_ramaddr", bus.ramaddr, 32'h200);
      chk("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
      chk("wr_dwait", bus.dwait, 1);
      tick();
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("wr_done_dwait", bus.dwait, 0);
    chk("wr_done_ramaddr", bus.ramaddr, 32'h200);
    tick();
    set_in(0,0,0,0,0,0,FREE,0);
    @(negedge CLK);
    chk("wr_after_ramWEN", bus.ramWEN, 0);
    tick();

    // Abort: dREN dropped after one GNT_D cycle, late ACCESS must not complete
    set_in(0,1,0,0,32'h500,0,FREE,0);
    tick();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk("ab_ramREN", bus.ramREN, 1);
    chk("ab_ramaddr", bus.ramaddr, 32'h500);
    tick();
    bus.dREN = 1'b0;
    tick();
    bus.dREN = 1'b1;
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("ab_idle_ramREN", bus.ramREN, 0);
    chk("ab_no_done", bus.dwait, 1);
    tick();
    @(negedge CLK);
    chk("ab_regrant_done", bus.dwait, 0);
    tick();
    set_in(0,0,0,0,0,0,FREE,0);
    tick(); tick();

    // ERROR reported by RAM during a grant
    set_in(0,1,0,0,32'h700,0,FREE,0);
    tick();
    bus.ramstate = ERROR;
    tick();
    @(negedge CLK);
    chk("rerr_err", bus.err, 1);
    chk("rerr_ramREN", bus.ramREN, 0);
    chk("rerr_dwait", bus.dwait, 1);
    tick();
    set_in(0,0,0,0,0,0,FREE,0);
    nRST = 1'b0;
    #1;
    chk("rerr_rst_err", bus.err, 0);
    nRST = 1'b1;
    tick();

    // Timeout: BUSY for TMO grant cycles
    set_in(1,0,0,32'h600,0,0,FREE,0);
    tick();
    bus.ramstate = BUSY;
    for (int k = 0; k < TMO; k++) begin
      @(negedge CLK);
      if (k == 0 || k == TMO - 1) begin
        chk($sformatf("tmo_ramREN_k%0d", k), bus.ramREN, 1);
        chk($sformatf("tmo_err_k%0d", k), bus.err, 0);
      end
      tick();
    end
    @(negedge CLK);
    chk("tmo_err", bus.err, 1);
    chk("tmo_ramREN", bus.ramREN, 0);
    chk("tmo_iwait", bus.iwait, 1);
    tick();
    bus.dREN = 1'b1;
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("tmo_sticky_err", bus.err, 1);
    chk("tmo_sticky_ramREN", bus.ramREN, 0);
    chk("tmo_sticky_dwait", bus.dwait, 1);
    chk("tmo_sticky_iwait", bus.iwait, 1);
    tick();
    set_in(0,0,0,0,0,0,FREE,0);
    nRST = 1'b0;
    #1;
    chk("tmo_rst_err", bus.err, 0);
    chk("tmo_rst_ramREN", bus.ramREN, 0);
    nRST = 1'b1;
    tick();

    // Asynchronous reset in the middle of a grant
    set_in(1,0,0,32'h800,0,0,FREE,0);
    tick();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk("mrst_pre_ramREN", bus.ramREN, 1);
    bus.ramstate = ACCESS;
    nRST = 1'b0;
    #1;
    chk("mrst_ramREN", bus.ramREN, 0);
    chk("mrst_no_done", bus.iwait, 1);
    chk("mrst_ramaddr", bus.ramaddr, 0);
    bus.iREN = 1'b0;
    nRST = 1'b1;
    tick();

    // Randomized traffic against the transaction-level model
    set_in(0,0,0,0,0,0,FREE,0);
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic ireq, dreq, access, owner;
      int r;
      if (m_errcyc >= 3) begin
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        model_reset();
      end
      if ($urandom_range(0, 5) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 5) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 7) == 0) bus.dWEN = ~bus.dWEN;
      bus.iaddr   = $urandom;
      bus.daddr   = $urandom;
      bus.dstore  = $urandom;
      bus.ramload = $urandom;
      r = $urandom_range(0, 99);
      if (m_err)
        bus.ramstate = ramstate_t'(r % 4);
      else if (cur.active)
        bus.ramstate = (r < 40) ? ACCESS : (r < 99) ? BUSY : ERROR;
      else
        bus.ramstate = (r < 50) ? FREE : BUSY;

      @(negedge CLK);
      ireq   = bus.iREN;
      dreq   = bus.dREN | bus.dWEN;
      access = (bus.ramstate == ACCESS);
      chk("rnd_iwait", bus.iwait, ireq && !(cur.active && !cur.is_d && access));
      chk("rnd_dwait", bus.dwait, dreq && !(cur.active && cur.is_d && access));
      chk("rnd_ramREN", bus.ramREN, cur.active && !cur.wr);
      chk("rnd_ramWEN", bus.ramWEN, cur.active && cur.wr);
      chk("rnd_ramaddr", bus.ramaddr, m_addr);
      chk("rnd_ramstore", bus.ramstore, m_store);
      chk("rnd_err", bus.err, m_err);
      if (ireq && !bus.iwait) chk("rnd_iload", bus.iload, bus.ramload);
      if (dreq && !bus.dwait) chk("rnd_dload", bus.dload, bus.ramload);

      if (m_err) begin
        m_errcyc++;
      end else if (cur.active) begin
        owner = cur.is_d ? dreq : ireq;
        if (access || !owner) begin
          cur.active = 0;
        end else if (bus.ramstate == ERROR || cur.age == TMO - 1) begin
          cur.active = 0;
          m_err = 1;
        end else begin
          cur.age++;
        end
      end else if (dreq && (m_starve < SM || !ireq)) begin
        cur = '{1, 1, bus.dWEN, 0};
        m_addr = bus.daddr;
        m_store = bus.dstore;
        m_starve = ireq ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      end else if (ireq) begin
        cur = '{1, 0, 0, 0};
        m_addr = bus.iaddr;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer that shares the single RAM port between the pipeline's instruction-fetch requester and its data-memory requester.
- Sits between the instruction/data request lines (imemREN/dmemREN/dmemWEN side) and the RAM model's ramREN/ramWEN/ramstate handshake.
- Latches one request per transaction, holds it on the RAM port until ramstate reports ACCESS, then returns data and a one-cycle completion to the winner.
- Data has priority, bounded by an anti-starvation counter; a timeout and an error path are included.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before instruction is forced.
- TIMEOUT, 64: cycles a grant may wait for ACCESS before moving to ERR.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  instruction not complete this cycle
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data not complete this cycle
- dload  out  32  data read data
- ramREN  out  1  RAM read strobe (registered)
- ramWEN  out  1  RAM write strobe (registered)
- ramaddr  out  32  RAM address (registered)
- ramstore  out  32  RAM write value (registered)
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- err  out  1  sticky error flag

Behaviour:
- Reset values:
  - State IDLE.
  - starve_cnt=0, tmo_cnt=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - err=0.
- Wait and load outputs are combinational:
  - iwait = iREN & ~idone; dwait = (dREN|dWEN) & ~ddone.
  - iload = ramload, dload = ramload; consumers sample them only when the matching wait is 0.
- States: IDLE, GNT_I, GNT_D, ERR.
- IDLE arbitration, evaluated each cycle; the chosen request is latched into the ram* registers at the clock edge:
  - Data pending and (starve_cnt<STARVE_MAX or ~iREN): go to GNT_D.
    - ramWEN=dWEN, ramREN=~dWEN.
    - If iREN is pending, starve_cnt++.
  - Otherwise, if iREN: go to GNT_I, ramREN=1, starve_cnt=0.
  - No request: stay in IDLE with ram strobes 0.
- GNT_x completion:
  - ramstate==ACCESS: done for x is asserted in this same cycle (wait low, load valid).
  - Next edge: go to IDLE, clear strobes, tmo_cnt=0.
- Latency: request first seen in IDLE at cycle N, strobes visible at N+1, earliest completion at N+1. IDLE always costs 1 cycle between transactions.
- Latched address and store data are held for the whole grant; requester input changes mid-grant are ignored until completion.
- Abort: if the granted requester drops its enable before ACCESS, go to IDLE, clear strobes, and do not assert done.
- Simultaneous dREN and dWEN: treated as a write.
- Timeout and error:
  - tmo_cnt increments each GNT cycle without ACCESS.
  - Reaching TIMEOUT-1 without ACCESS, or ramstate==ERROR in a GNT state: go to ERR.
  - In ERR: err=1, strobes 0, waits follow requests (held high). Only nRST exits ERR.
- starve_cnt saturates at STARVE_MAX and resets when iREN is low in IDLE.
- Asynchronous reset mid-grant: strobes drop immediately, no done is produced, and state and counters clear.

Decomposition:
- Shared package (cpu_types_pkg or dp_types_pkg):
  - arb_state_t enum {IDLE, GNT_I, GNT_D, ERR}.
  - Reuse the existing ramstate_t.
  - Default STARVE_MAX and TIMEOUT as localparams.
- Optional sub-module arb_priority: combinational grant select from (iREN, dREN|dWEN, starve_cnt). Counters and the FSM stay in mem_arbiter.

Test Plan:
- Instruction only: iREN=1, iaddr=0x40, RAM gives ACCESS 2 cycles after ramREN with ramload=0x8C010004.
  - ramaddr=0x40 and ramREN=1 from N+1.
  - iwait=0 and iload=0x8C010004 at N+2.
  - IDLE at N+3.
- Contention: iREN and dREN both high, daddr=0x100.
  - GNT_D is served first; dload is valid on ACCESS.
  - GNT_I follows after one IDLE cycle.
  - iwait stays 1 throughout the data transaction.
- Starvation: dREN held high continuously with iREN high, STARVE_MAX=4.
  - Exactly 4 data grants, then 1 instruction grant, then starve_cnt=0.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, daddr changed to 0x300 mid-grant.
  - ramWEN=1, ramaddr=0x200 and ramstore=0xDEADBEEF are held until ACCESS.
- Abort and timeout:
  - Drop dREN after 1 GNT_D cycle: IDLE next cycle, no dwait=0 pulse.
  - Separately, hold ramstate=BUSY for 64 cycles: ERR, err=1, strobes 0.
  - nRST low: err=0 and state IDLE immediately.
